// File: rtl/mem_access_stage.sv
// mem_access_stage
//    MEM pipeline stage. Serialises loads and stores into single-byte RAM
//    accesses through the arbiter, assembles load bytes little-endian and
//    applies sign/zero extension, and forwards non-memory results straight
//    through to MEM/WB with no added latency.
//
// Ports
//    clk, rst          clock, asynchronous active-high reset
//    rdy               global ready; low freezes every register, ram_en = 0
//    optype, opname    instruction class / opcode from EX/MEM
//    mem_rd_addr       destination register from EX/MEM
//    mem_rd_data       ALU result, or effective address for loads/stores
//    mem_s_data        store data
//    ram_din, ram_gnt  read byte (valid the cycle after a granted read), grant
//    ram_en, ram_wr    access strobe, 1 = write
//    ram_addr, ram_dout byte address, write byte
//    wb_rd_addr/data   writeback to MEM/WB (`ZeroRegAddr = no write)
//    stall_req         hold EX/MEM and earlier stages
//
// state | meaning
// IDLE  | no access in flight; pass-through, or launch a load/store
// ISSUE | presenting byte issue_cnt to the arbiter until granted
// WAIT  | all load bytes issued, collecting the final read byte
// DONE  | result presented to MEM/WB for one cycle, stall released

`ifndef OpTypeLen
`define OpTypeLen 3
`endif
`ifndef OpLen
`define OpLen 4
`endif
`ifndef RegAddrLen
`define RegAddrLen 5
`endif
`ifndef ZeroRegAddr
`define ZeroRegAddr 5'b00000
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef OpTypeLoad
`define OpTypeLoad 3'd2
`endif
`ifndef OpTypeStore
`define OpTypeStore 3'd3
`endif
`ifndef OpLb
`define OpLb  4'd2
`define OpLh  4'd3
`define OpLw  4'd4
`define OpLbu 4'd5
`define OpLhu 4'd6
`define OpSb  4'd7
`define OpSh  4'd8
`define OpSw  4'd9
`endif

module mem_access_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int XLEN       = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic [`OpTypeLen-1:0]  optype,
   input  logic [`OpLen-1:0]      opname,
   input  logic [`RegAddrLen-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]        mem_rd_data,
   input  logic [XLEN-1:0]        mem_s_data,
   input  logic [7:0]             ram_din,
   input  logic                   ram_gnt,
   output logic                   ram_en,
   output logic                   ram_wr,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic [7:0]             ram_dout,
   output logic [`RegAddrLen-1:0] wb_rd_addr,
   output logic [XLEN-1:0]        wb_rd_data,
   output logic                   stall_req
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                   state, state_nxt;

   logic [ADDR_WIDTH-1:0]    eff_q;
   logic [XLEN-1:0]          sdata_q;
   logic [XLEN-1:0]          ld_buf;
   logic [`OpLen-1:0]        op_q;
   logic [`RegAddrLen-1:0]   rd_q;
   logic                     is_load_q;
   logic [2:0]               issue_cnt;
   logic [2:0]               recv_cnt;
   logic                     rd_pend;

   logic                     is_load_in;
   logic                     mem_op;
   logic                     launch;
   logic                     issue_fire;
   logic                     last_issue;
   logic                     capture;
   logic [2:0]               nbytes;
   logic [7:0]               st_byte;
   logic [XLEN-1:0]          load_val;

   assign is_load_in = (optype == `OpTypeLoad);
   assign mem_op     = is_load_in || (optype == `OpTypeStore);
   assign launch     = rdy && (state == IDLE) && mem_op;
   assign issue_fire = rdy && (state == ISSUE) && ram_gnt;
   assign last_issue = (issue_cnt == nbytes - 3'd1);
   // A granted read returns its byte one cycle later; the flag survives
   // rdy=0 cycles and fires on the next ready cycle.
   assign capture    = rdy && rd_pend;

   always_comb begin
      case (op_q)
         `OpLb, `OpLbu, `OpSb: nbytes = 3'd1;
         `OpLh, `OpLhu, `OpSh: nbytes = 3'd2;
         default:              nbytes = 3'd4;
      endcase
   end

   always_comb begin
      case (issue_cnt[1:0])
         2'd0:    st_byte = sdata_q[7:0];
         2'd1:    st_byte = sdata_q[15:8];
         2'd2:    st_byte = sdata_q[23:16];
         default: st_byte = sdata_q[31:24];
      endcase
   end

   always_comb begin
      case (op_q)
         `OpLb:   load_val = {{(XLEN-8){ld_buf[7]}}, ld_buf[7:0]};
         `OpLbu:  load_val = {{(XLEN-8){1'b0}}, ld_buf[7:0]};
         `OpLh:   load_val = {{(XLEN-16){ld_buf[15]}}, ld_buf[15:0]};
         `OpLhu:  load_val = {{(XLEN-16){1'b0}}, ld_buf[15:0]};
         default: load_val = ld_buf;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (rdy) begin
         state <= state_nxt;
      end
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_op) state_nxt = ISSUE;
         ISSUE:   if (ram_gnt && last_issue) state_nxt = is_load_q ? WAIT : DONE;
         WAIT:    if (rd_pend) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      ram_en     = 1'b0;
      ram_wr     = 1'b0;
      ram_addr   = '0;
      ram_dout   = 8'h00;
      wb_rd_addr = `ZeroRegAddr;
      wb_rd_data = `ZeroWord;
      stall_req  = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               stall_req = 1'b1;
            end else begin
               wb_rd_addr = mem_rd_addr;
               wb_rd_data = mem_rd_data;
            end
         end
         ISSUE: begin
            ram_en    = rdy;
            ram_wr    = !is_load_q;
            ram_addr  = eff_q + ADDR_WIDTH'(issue_cnt);
            ram_dout  = is_load_q ? 8'h00 : st_byte;
            stall_req = 1'b1;
         end
         WAIT: begin
            stall_req = 1'b1;
         end
         DONE: begin
            if (is_load_q) begin
               wb_rd_addr = rd_q;
               wb_rd_data = load_val;
            end
         end
         default: ;
      endcase
   end

   // datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eff_q     <= '0;
         sdata_q   <= '0;
         ld_buf    <= '0;
         op_q      <= '0;
         rd_q      <= `ZeroRegAddr;
         is_load_q <= 1'b0;
         issue_cnt <= 3'd0;
         recv_cnt  <= 3'd0;
         rd_pend   <= 1'b0;
      end else if (rdy) begin
         rd_pend <= issue_fire && is_load_q;
         if (issue_fire) begin
            issue_cnt <= issue_cnt + 3'd1;
         end
         if (capture) begin
            recv_cnt <= recv_cnt + 3'd1;
            case (recv_cnt[1:0])
               2'd0:    ld_buf[7:0]   <= ram_din;
               2'd1:    ld_buf[15:8]  <= ram_din;
               2'd2:    ld_buf[23:16] <= ram_din;
               default: ld_buf[31:24] <= ram_din;
            endcase
         end
         if (launch) begin
            eff_q     <= mem_rd_data[ADDR_WIDTH-1:0];
            sdata_q   <= mem_s_data;
            op_q      <= opname;
            rd_q      <= mem_rd_addr;
            is_load_q <= is_load_in;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            ld_buf    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   localparam logic [2:0] T_NONE = 3'd0, T_ALU = 3'd1, T_LOAD = 3'd2, T_STORE = 3'd3;
   localparam logic [3:0] O_NOP = 4'd0, O_ADD = 4'd1, O_LB = 4'd2, O_LH = 4'd3,
                          O_LW = 4'd4, O_LBU = 4'd5, O_LHU = 4'd6, O_SB = 4'd7,
                          O_SH = 4'd8, O_SW = 4'd9;
   localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic [2:0]  optype = 3'd0;
   logic [3:0]  opname = 4'd0;
   logic [4:0]  mem_rd_addr = 5'd0;
   logic [31:0] mem_rd_data = 32'd0;
   logic [31:0] mem_s_data = 32'd0;
   logic [7:0]  ram_din = 8'd0;
   logic        ram_gnt = 1'b1;
   logic        ram_en, ram_wr;
   logic [31:0] ram_addr;
   logic [7:0]  ram_dout;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;
   logic        stall_req;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mem     [4096];
   logic [7:0] ref_mem [4096];

   always #5 clk = ~clk;

   mem_access_stage #(.ADDR_WIDTH(32), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .optype(optype), .opname(opname),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_s_data(mem_s_data),
      .ram_din(ram_din), .ram_gnt(ram_gnt), .ram_en(ram_en), .ram_wr(ram_wr),
      .ram_addr(ram_addr), .ram_dout(ram_dout), .wb_rd_addr(wb_rd_addr),
      .wb_rd_data(wb_rd_data), .stall_req(stall_req)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // byte-wide RAM behind the arbiter; read data appears the next cycle
   always @(posedge clk) begin
      if (ram_en && ram_gnt) begin
         if (ram_wr) mem[ram_addr[11:0]] = ram_dout;
         else        ram_din <= mem[ram_addr[11:0]];
      end
   end

   // ---------------- reference model (transaction level) ----------------
   bit          m_busy = 0, m_load = 0, m_pend = 0;
   int          m_n = 0, m_iss = 0, m_rcv = 0;
   logic [31:0] m_eff = 0, m_sd = 0, m_res = 0;
   logic [4:0]  m_rd = 0;

   function automatic int nb(input logic [3:0] op);
      case (op)
         O_LB, O_LBU, O_SB: return 1;
         O_LH, O_LHU, O_SH: return 2;
         default:           return 4;
      endcase
   endfunction

   function automatic logic [7:0] sbyte(input logic [31:0] d, input int k);
      return 8'(d >> (8 * k));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_pend = 0; m_iss = 0; m_rcv = 0;
      end else if (rdy) begin
         if (!m_busy) begin
            if (optype == T_LOAD || optype == T_STORE) begin
               logic [31:0] w;
               m_busy = 1; m_load = (optype == T_LOAD); m_n = nb(opname);
               m_eff = mem_rd_data; m_sd = mem_s_data; m_rd = mem_rd_addr;
               m_iss = 0; m_rcv = 0;
               w = 0;
               for (int k = 0; k < m_n; k++)
                  w = w | (32'(ref_mem[12'(m_eff + 32'(k))]) << (8 * k));
               case (opname)
                  O_LB:    m_res = $signed(w[7:0]);
                  O_LH:    m_res = $signed(w[15:0]);
                  O_LBU:   m_res = w & 32'h0000_00FF;
                  O_LHU:   m_res = w & 32'h0000_FFFF;
                  default: m_res = w;
               endcase
            end
         end else if (m_iss < m_n) begin
            if (m_pend) begin m_rcv++; m_pend = 0; end
            if (ram_gnt) begin
               if (!m_load) ref_mem[12'(m_eff + 32'(m_iss))] = sbyte(m_sd, m_iss);
               m_pend = m_load;
               m_iss++;
            end
         end else if (m_load && m_rcv < m_n) begin
            if (m_pend) begin m_rcv++; m_pend = 0; end
         end else begin
            m_busy = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic        e_en, e_wr, e_st;
      logic [31:0] e_addr, e_wd;
      logic [4:0]  e_wa;
      bit          issuing;
      issuing = m_busy && (m_iss < m_n);
      e_en = 0; e_wr = 0; e_st = 0; e_addr = 0; e_wd = 0; e_wa = 0;
      if (!m_busy) begin
         if (optype == T_LOAD || optype == T_STORE) e_st = 1;
         else begin e_wa = mem_rd_addr; e_wd = mem_rd_data; end
      end else if (issuing) begin
         e_en = rdy; e_wr = !m_load; e_st = 1;
         e_addr = m_eff + 32'(m_iss);
      end else if (m_load && m_rcv < m_n) begin
         e_st = 1;
      end else if (m_load) begin
         e_wa = m_rd; e_wd = m_res;
      end
      chk("ram_en", ram_en, e_en);
      chk("ram_wr", ram_wr, e_wr);
      chk("stall_req", stall_req, e_st);
      chk("wb_rd_addr", wb_rd_addr, e_wa);
      chk("wb_rd_data", wb_rd_data, e_wd);
      if (issuing) chk("ram_addr", ram_addr, e_addr);
      if (issuing && !m_load) chk("ram_dout", ram_dout, sbyte(m_sd, m_iss));
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input logic [2:0] ot, input logic [3:0] on, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] sd);
      optype = ot; opname = on; mem_rd_addr = rd; mem_rd_data = a; mem_s_data = sd;
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      mem[a[11:0]] = d;
      ref_mem[a[11:0]] = d;
   endtask

   // Called just after a rising edge. Bit i of gp/rp drives ram_gnt/rdy in
   // cycle i (cycle 0 is the cycle the op first appears). bc counts stall
   // cycles after cycle 0; r/ra are taken from the result cycle.
   task automatic do_op(input logic [2:0] ot, input logic [3:0] on, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] gp, input logic [31:0] rp,
                        output logic [31:0] r, output logic [4:0] ra, output int bc);
      int cyc;
      bit done;
      cyc = 0; done = 0; bc = 0; r = 0; ra = 0;
      set_in(ot, on, rd, a, sd);
      while (!done && cyc < 200) begin
         ram_gnt = (cyc < 32) ? gp[cyc] : 1'b1;
         rdy     = (cyc < 32) ? rp[cyc] : 1'b1;
         @(negedge clk);
         if (rdy && !stall_req) begin
            r = wb_rd_data; ra = wb_rd_addr; done = 1;
         end else if (cyc > 0 && stall_req) begin
            bc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL op_timeout: op %0d still stalled after %0d cycles, expected completion", on, cyc);
      end
      set_in(T_NONE, O_NOP, 5'd0, 32'd0, 32'd0);
      ram_gnt = 1'b1; rdy = 1'b1;
   endtask

   initial begin
      logic [31:0] r;
      logic [4:0]  ra;
      int          bc;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      poke(32'h200, 8'h80);
      poke(32'h300, 8'h34); poke(32'h301, 8'h92);
      poke(32'h400, 8'h44); poke(32'h401, 8'h33); poke(32'h402, 8'h22); poke(32'h403, 8'h11);
      poke(32'hFFE, 8'hA1); poke(32'hFFF, 8'hB2); poke(32'h000, 8'hC3); poke(32'h001, 8'hD4);
      for (int i = 0; i < 4; i++) poke(32'h500 + 32'(i), 8'h5A);

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ram_en", ram_en, 0);
      chk("reset ram_wr", ram_wr, 0);
      chk("reset ram_addr", ram_addr, 0);
      chk("reset ram_dout", ram_dout, 0);
      chk("reset wb_rd_addr", wb_rd_addr, 0);
      chk("reset wb_rd_data", wb_rd_data, 0);
      chk("reset stall_req", stall_req, 0);
      @(posedge clk); #1 rst = 1'b0;

      do_op(T_ALU, O_ADD, 5'd5, 32'h0000_1234, 32'd0, ALL1, ALL1, r, ra, bc);
      chk("add wb_data", r, 32'h0000_1234);
      chk("add wb_addr", ra, 5);
      chk("add stall cycles", bc, 0);

      do_op(T_STORE, O_SW, 5'd0, 32'h100, 32'hDEAD_BEEF, ALL1, ALL1, r, ra, bc);
      chk("sw stall cycles", bc, 4);
      chk("sw wb_addr", ra, 0);
      chk("sw byte0", mem[12'h100], 8'hEF);
      chk("sw byte1", mem[12'h101], 8'hBE);
      chk("sw byte2", mem[12'h102], 8'hAD);
      chk("sw byte3", mem[12'h103], 8'hDE);

      do_op(T_LOAD, O_LB, 5'd3, 32'h200, 32'd0, ALL1, ALL1, r, ra, bc);
      chk("lb data", r, 32'hFFFF_FF80);
      chk("lb addr", ra, 3);
      chk("lb stall cycles", bc, 2);
      do_op(T_LOAD, O_LBU, 5'd3, 32'h200, 32'd0, ALL1, ALL1, r, ra, bc);
      chk("lbu data", r, 32'h0000_0080);
      do_op(T_LOAD, O_LH, 5'd7, 32'h300, 32'd0, ALL1, ALL1, r, ra, bc);
      chk("lh data", r, 32'hFFFF_9234);
      do_op(T_LOAD, O_LHU, 5'd7, 32'h300, 32'd0, ALL1, ALL1, r, ra, bc);
      chk("lhu data", r, 32'h0000_9234);

      do_op(T_LOAD, O_LW, 5'd9, 32'h400, 32'd0, 32'hFFFF_FFF3, ALL1, r, ra, bc);
      chk("lw denied data", r, 32'h1122_3344);
      chk("lw denied stall cycles", bc, 7);

      do_op(T_LOAD, O_LW, 5'd10, 32'h400, 32'd0, ALL1, 32'hFFFF_FFE3, r, ra, bc);
      chk("lw rdy-drop data", r, 32'h1122_3344);
      chk("lw rdy-drop addr", ra, 10);
      chk("lw rdy-drop stall cycles", bc, 8);

      do_op(T_LOAD, O_LW, 5'd11, 32'hFFFF_FFFE, 32'd0, ALL1, ALL1, r, ra, bc);
      chk("lw wrap data", r, 32'hD4C3_B2A1);

      do_op(T_LOAD, O_LW, 5'd0, 32'h400, 32'd0, ALL1, ALL1, r, ra, bc);
      chk("lw x0 addr", ra, 0);

      do_op(T_STORE, O_SH, 5'd0, 32'h600, 32'h1234_ABCD, ALL1, ALL1, r, ra, bc);
      chk("sh stall cycles", bc, 2);
      do_op(T_LOAD, O_LH, 5'd4, 32'h600, 32'd0, ALL1, ALL1, r, ra, bc);
      chk("sh/lh data", r, 32'hFFFF_ABCD);

      // reset while byte 2 of a store is on the bus
      set_in(T_STORE, O_SW, 5'd0, 32'h500, 32'hCAFE_F00D);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("abort byte2 addr", ram_addr, 32'h502);
      #2 rst = 1'b1;
      set_in(T_NONE, O_NOP, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("abort ram_en", ram_en, 0);
      chk("abort stall_req", stall_req, 0);
      chk("abort ram_addr", ram_addr, 0);
      chk("abort wb_rd_addr", wb_rd_addr, 0);
      @(posedge clk); #1 rst = 1'b0;
      chk("abort mem 500", mem[12'h500], 8'h0D);
      chk("abort mem 501", mem[12'h501], 8'hF0);
      chk("abort mem 502", mem[12'h502], 8'h5A);
      chk("abort mem 503", mem[12'h503], 8'h5A);

      for (int i = 0; i < 300; i++) begin
         logic [2:0]  ot;
         logic [3:0]  on;
         logic [31:0] a;
         int          sel;
         sel = $urandom_range(0, 9);
         if (sel < 3) begin
            ot = T_ALU; on = O_ADD;
         end else if (sel == 3) begin
            ot = T_NONE; on = O_NOP;
         end else if (sel < 7) begin
            ot = T_LOAD;
            case ($urandom_range(0, 4))
               0: on = O_LB;
               1: on = O_LH;
               2: on = O_LW;
               3: on = O_LBU;
               default: on = O_LHU;
            endcase
         end else begin
            ot = T_STORE;
            case ($urandom_range(0, 2))
               0: on = O_SB;
               1: on = O_SH;
               default: on = O_SW;
            endcase
         end
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else                           a = 32'($urandom_range(0, 4095));
         do_op(ot, on, 5'($urandom), a, $urandom, $urandom | $urandom,
               $urandom | $urandom, r, ra, bc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage; consumes the EX/MEM register outputs (rd address, rd data or effective address, store data, optype, opname).
- Drives the byte-wide RAM port through the memory arbiter. Serialises LB/LH/LW/LBU/LHU/SB/SH/SW into byte accesses.
- Presents the writeback result to the MEM/WB register.
- Raises a stall request to the stall controller while an access is in flight.

Parameters:
ADDR_WIDTH, 32, width of the RAM byte address
XLEN, 32, register/data width; must be 32

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rdy  in  1  global ready; low freezes all state, mem_en forced 0
optype  in  `OpTypeLen  instruction type from EX/MEM
opname  in  `OpLen  opcode from EX/MEM
mem_rd_addr  in  `RegAddrLen  destination register
mem_rd_data  in  XLEN  ALU result; effective address for loads/stores
mem_s_data  in  XLEN  store data
ram_din  in  8  read byte; valid the cycle after the read was issued
ram_gnt  in  1  arbiter grants the RAM port this cycle
ram_en  out  1  access issued this cycle (qualified by ram_gnt)
ram_wr  out  1  1 = write, 0 = read
ram_addr  out  ADDR_WIDTH  byte address
ram_dout  out  8  write byte
wb_rd_addr  out  `RegAddrLen  destination to MEM/WB; `ZeroRegAddr = no write
wb_rd_data  out  XLEN  writeback value
stall_req  out  1  request to stall the EX/MEM register and all earlier stages

Behaviour:
- Reset (async):
  - state=IDLE; byte counters=0; load buffer=0; latched address/data/op=0.
  - ram_en=0, ram_wr=0, ram_addr=0, ram_dout=0.
  - wb_rd_addr=`ZeroRegAddr, wb_rd_data=`ZeroWord, stall_req=0.
- Byte count N: byte ops=1, halfword ops=2, word ops=4. Byte k goes to address eff+k, little-endian, with ADDR_WIDTH wrap-around.
- Non-memory ops (IDLE only):
  - Pass through combinationally: wb_rd_addr=mem_rd_addr, wb_rd_data=mem_rd_data.
  - stall_req=0; zero added latency.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, load/store present on inputs (rdy=1):
  - stall_req=1 combinationally in the same cycle.
  - Latch eff address, store data, opname, rd_addr.
  - Set issue_cnt=0, recv_cnt=0. Next state = ISSUE.
  - wb_rd_addr=`ZeroRegAddr (bubble).
- ISSUE:
  - ram_en=1; ram_addr=eff+issue_cnt.
  - Stores: ram_wr=1, ram_dout=store_data[8*issue_cnt+:8]. Loads: ram_wr=0.
  - An issue takes effect only when ram_gnt=1, and then issue_cnt increments. If ram_gnt=0, hold address/data and retry next cycle.
  - After issuing byte N-1: store -> DONE; load -> WAIT.
- Load receive (any state):
  - In the cycle after each granted read, capture ram_din into buf[8*recv_cnt+:8] and increment recv_cnt.
  - This holds regardless of the current ram_gnt.
- WAIT:
  - ram_en=0. Capture the final byte, then go to DONE.
- DONE:
  - stall_req=0.
  - Loads: wb_rd_addr=latched rd. wb_rd_data = buf sign-extended (LB from bit 7, LH from bit 15) or zero-extended (LBU/LHU); LW = buf.
  - Stores: wb_rd_addr=`ZeroRegAddr, wb_rd_data=`ZeroWord.
  - Next state = IDLE unconditionally. The EX/MEM register advances at this edge, so the same instruction is never re-executed.
- Latency: load = N issue cycles (minimum, plus denied-grant cycles) + 1 WAIT + 1 DONE. Store = N issue cycles + 1 DONE.
- stall_req is 1 in ISSUE and WAIT, and in IDLE when a memory op is present.
- rdy=0: all registers hold; ram_en=0; no byte capture. The pending read-capture flag is held and fires on the first rdy=1 cycle.
- rd_addr x0 on a load: access is still performed; wb_rd_addr = `ZeroRegAddr.
- Reset mid-operation: abort immediately to IDLE. Bytes already written by a store stay written; the partial load buffer is discarded.

Test Plan:
- ADD result 0x0000_1234 to rd=5 -> same-cycle wb_rd_addr=5, wb_rd_data=0x1234, stall_req=0, ram_en=0.
- SW eff=0x100, data 0xDEADBEEF, ram_gnt always 1 -> writes EF,BE,AD,DE to 0x100..0x103 in 4 consecutive cycles; stall_req high 4 cycles; DONE shows wb_rd_addr=0.
- LB from 0x200 holding 0x80, rd=3 -> wb_rd_data=0xFFFFFF80. LBU same address -> 0x00000080. LH of bytes 0x34,0x92 -> 0xFFFF9234.
- LW with ram_gnt low on cycles 2 and 3 -> address held during denial, no duplicate byte, result correct, total stall = 4+2+1 cycles.
- rdy dropped for 3 cycles mid-LW -> no ram_en, counters frozen; resumes and returns the correct word.
- rst asserted during byte 2 of SW -> outputs at reset values next edge, state IDLE, bytes 0..1 written, bytes 2..3 untouched.
